// File: rtl/dsp_channel_scheduler.sv
// dsp_channel_scheduler
// Shares one start/done compute engine across NUM_OF_CHANNELS channels. Each accepted frame_start
// walks the sampled channel mask lowest index first. Each channel either completes or is abandoned
// after TIMEOUT_CYCLES wait cycles. ready is raised once the whole frame has been served.
module dsp_channel_scheduler #(
    parameter int NUM_OF_CHANNELS = 8,
    parameter int CH_IDX_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk_i,
    input  logic                       a_rst_i,
    input  logic                       s_rst_i,
    input  logic                       enable_i,
    input  logic                       frame_start_i,
    input  logic [NUM_OF_CHANNELS-1:0] ch_mask_i,
    input  logic                       eng_done_i,
    output logic                       eng_start_o,
    output logic [CH_IDX_WIDTH-1:0]    eng_ch_o,
    output logic                       busy_o,
    output logic                       ready_o,
    output logic [NUM_OF_CHANNELS-1:0] done_map_o,
    output logic [NUM_OF_CHANNELS-1:0] timeout_map_o,
    output logic                       overrun_o
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_OF_CHANNELS-1:0] pending_q, pending_d;
    logic [TIMER_WIDTH-1:0]     timer_q, timer_d;
    logic                       eng_start_q, eng_start_d;
    logic [CH_IDX_WIDTH-1:0]    eng_ch_q, eng_ch_d;
    logic                       busy_q, busy_d;
    logic                       ready_q, ready_d;
    logic [NUM_OF_CHANNELS-1:0] done_map_q, done_map_d;
    logic [NUM_OF_CHANNELS-1:0] timeout_map_q, timeout_map_d;
    logic                       overrun_q, overrun_d;
    logic                       chan_end;
    logic [CH_IDX_WIDTH-1:0]    low_idx;

    // Next-state logic: the FSM and every registered output are computed together so each output
    // is a flop that already carries the value belonging to the state being entered.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        timer_d       = timer_q;
        eng_start_d   = eng_start_q;
        eng_ch_d      = eng_ch_q;
        busy_d        = busy_q;
        ready_d       = ready_q;
        done_map_d    = done_map_q;
        timeout_map_d = timeout_map_q;
        overrun_d     = overrun_q;
        chan_end      = 1'b0;
        low_idx       = '0;

        if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        pending_d     = ch_mask_i;
                        done_map_d    = '0;
                        timeout_map_d = '0;
                        ready_d       = 1'b0;
                        state_d       = (ch_mask_i != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    timer_d = timer_q + 1'b1;
                    if (eng_done_i) begin
                        done_map_d[eng_ch_q] = 1'b1;
                        pending_d[eng_ch_q]  = 1'b0;
                        chan_end             = 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_map_d[eng_ch_q] = 1'b1;
                        pending_d[eng_ch_q]     = 1'b0;
                        chan_end                = 1'b1;
                    end
                    if (chan_end) begin
                        state_d = (pending_d != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (frame_start_i && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end

            for (int i = NUM_OF_CHANNELS - 1; i >= 0; i--) begin
                if (pending_d[i]) begin
                    low_idx = CH_IDX_WIDTH'(i);
                end
            end

            eng_start_d = (state_d == ST_ISSUE);
            if (state_d == ST_ISSUE) begin
                eng_ch_d = low_idx;
            end
            busy_d = (state_d != ST_IDLE);
        end

        if (s_rst_i) begin
            state_d       = ST_IDLE;
            pending_d     = '0;
            timer_d       = '0;
            eng_start_d   = 1'b0;
            eng_ch_d      = '0;
            busy_d        = 1'b0;
            ready_d       = 1'b0;
            done_map_d    = '0;
            timeout_map_d = '0;
            overrun_d     = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by a_rst_i.
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            timer_q       <= '0;
            eng_start_q   <= 1'b0;
            eng_ch_q      <= '0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            done_map_q    <= '0;
            timeout_map_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            timer_q       <= timer_d;
            eng_start_q   <= eng_start_d;
            eng_ch_q      <= eng_ch_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            done_map_q    <= done_map_d;
            timeout_map_q <= timeout_map_d;
            overrun_q     <= overrun_d;
        end
    end

    // The start flop holds through a freeze so the ISSUE cycle still launches the engine once
    // enable returns. Gating it with enable_i keeps the engine from seeing a start while frozen.
    assign eng_start_o   = eng_start_q & enable_i;
    assign eng_ch_o      = eng_ch_q;
    assign busy_o        = busy_q;
    assign ready_o       = ready_q;
    assign done_map_o    = done_map_q;
    assign timeout_map_o = timeout_map_q;
    assign overrun_o     = overrun_q;

endmodule
